// File: rtl/boolean_bist_pkg.sv
// boolean_bist_pkg: shared state encoding and vector-count helper for the BIST engine
package boolean_bist_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  function automatic int vec_count(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/settle_timer.sv
// settle_timer: down-counter reloaded with CYC-1, expire flags that the hold time has elapsed
module settle_timer #(
  parameter int CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);
  localparam int W = CYC > 1 ? $clog2(CYC) : 1;
  logic [W-1:0] r_cnt;
  // reload while not settling, otherwise count down to zero and stop there
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (load) r_cnt <= W'(CYC - 1);
    else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
  end
  assign expire = r_cnt == '0;
endmodule

// File: rtl/boolean_bist.sv
// boolean_bist: exhaustive truth-table self-test for an N-input, 1-output combinational block
module boolean_bist
  import boolean_bist_pkg::*;
#(
  parameter  int N          = 4,
  parameter  int SETTLE_CYC = 1,
  localparam int NV         = vec_count(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NV-1:0] expected,
  output logic [N-1:0]  dut_in,
  input  logic          dut_y,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [N:0]    fail_count,
  output logic [N-1:0]  first_fail_idx,
  output logic          first_fail_valid
);
  state_t        r_state, w_next;
  logic [NV-1:0] r_exp;
  logic [N-1:0]  r_idx, r_ff_idx;
  logic [N:0]    r_fail, w_fail_next;
  logic          r_ff_valid, r_pass;
  logic          w_expire, w_mis, w_last;

  settle_timer #(.CYC(SETTLE_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (r_state != SETTLE),
    .expire (w_expire)
  );

  assign w_mis       = dut_y != r_exp[r_idx];
  assign w_last      = r_idx == N'(NV - 1);
  assign w_fail_next = r_fail + (N+1)'(w_mis);

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  // next-state: start only counts in IDLE, DONE always lasts one cycle
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   w_next = start ? SETTLE : IDLE;
      SETTLE: w_next = w_expire ? CHECK : SETTLE;
      CHECK:  w_next = w_last ? DONE : SETTLE;
      DONE:   w_next = IDLE;
    endcase
  end

  // snapshot on start, score each vector in CHECK, register pass on the way into DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp      <= '0;
      r_idx      <= '0;
      r_fail     <= '0;
      r_ff_idx   <= '0;
      r_ff_valid <= 1'b0;
      r_pass     <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_exp      <= expected;
      r_idx      <= '0;
      r_fail     <= '0;
      r_ff_idx   <= '0;
      r_ff_valid <= 1'b0;
      r_pass     <= 1'b0;
    end else if (r_state == CHECK) begin
      r_fail <= w_fail_next;
      if (w_mis && !r_ff_valid) begin
        r_ff_idx   <= r_idx;
        r_ff_valid <= 1'b1;
      end
      if (w_last) r_pass <= w_fail_next == '0;
      else r_idx <= r_idx + N'(1);
    end
  end

  assign dut_in           = r_idx;
  assign busy             = r_state == SETTLE || r_state == CHECK;
  assign done             = r_state == DONE;
  assign pass             = r_pass;
  assign fail_count       = r_fail;
  assign first_fail_idx   = r_ff_idx;
  assign first_fail_valid = r_ff_valid;
endmodule

// File: doc/boolean_bist.md
Name: boolean_bist

Overview:
- Hardware self-test engine for small combinational gate-level blocks such as boolean_function and the half adder.
- Drives every input combination of an N-input, 1-output DUT and samples the DUT output after a fixed settle time.
- Compares each sample against a truth-table word that is captured at start, and reports pass/fail, the mismatch count and the first failing vector.
- Sits beside the DUT in place of a simulation-only stimulus/monitor bench, so the same check runs on silicon or FPGA.

Parameters:
- N, 4: number of DUT inputs. Range 1..8.
- SETTLE_CYC, 1: cycles each vector is held before sampling. Must be ≥1.
- Derived localparam NV = 2**N: vector count.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: begin a test run. Sampled only in IDLE.
- expected, in, NV: truth table. Bit i is the expected y for input vector i. Captured on the accepted start.
- dut_in, out, N: vector driven to the DUT. Bit N-1 maps to input a.
- dut_y, in, 1: DUT output.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse at the end of a run.
- pass, out, 1: high when the last run had zero mismatches. Held until the next accepted start.
- fail_count, out, N+1: number of mismatching vectors. Saturation is not needed, since the maximum is NV.
- first_fail_idx, out, N: index of the lowest failing vector.
- first_fail_valid, out, 1: first_fail_idx is meaningful.

Behaviour:
- Reset: state=IDLE. busy, done, pass, fail_count, first_fail_idx, first_fail_valid, dut_in, the internal index and the settle counter are all 0. The expected snapshot is cleared to 0.
- Reset mid-run: abort at once, return to the reset values on the next edge. No done pulse.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - On start=1 at edge t, the edge t captures expected into exp_q.
  - It also sets idx=0, dut_in=0, wcnt=0, and clears fail_count, first_fail_idx, first_fail_valid and pass.
  - busy=1 from cycle t+1; state goes to SETTLE.
- SETTLE: wcnt increments each cycle. When wcnt==SETTLE_CYC-1, go to CHECK with wcnt reset to 0.
- CHECK:
  - Sample dut_y and compare it with exp_q[idx].
  - On mismatch: fail_count++. If first_fail_valid==0, load first_fail_idx=idx and set first_fail_valid=1.
  - If idx==NV-1, go to DONE.
  - Otherwise idx++, dut_in=idx+1 (updated on the same edge), and go to SETTLE.
- DONE (one cycle):
  - done=1 and busy=0.
  - pass=(fail_count==0) is registered on entry, so it is valid in the same cycle as done.
  - Next state is IDLE. dut_in holds its last value.
- Timing: each vector takes SETTLE_CYC+1 cycles. With an accepted start at edge t, done is high in cycle t + NV*(SETTLE_CYC+1) + 1.
  - For N=4 and SETTLE_CYC=1, done is high 33 cycles after start.
- Start while busy or in DONE is ignored.
- Start held high continuously: a new run is accepted in the first IDLE cycle after DONE.
- Changes to expected during a run have no effect, because only exp_q is used.
- fail_count width N+1 holds NV exactly. No wrap-around is possible.

Decomposition:
- Package boolean_bist_pkg holds:
  - the state enum typedef (IDLE, SETTLE, CHECK, DONE);
  - a function vec_count(n) returning 2**n.
- One natural sub-module, settle_timer: a down-counter loaded with SETTLE_CYC-1 that outputs an expire flag. It is reusable by other gate-level test engines.
- Everything else stays in a single module.

Test Plan:
- Clean run, parity: DUT model is the 4-input XOR and expected=16'h6996.
  - Required: done pulses 33 cycles after start, pass=1, fail_count=0, first_fail_valid=0.
  - dut_in steps 0..15, each value held 2 cycles.
- Single fault: same DUT, expected=16'h6997 (bit 0 flipped).
  - Required: pass=0, fail_count=1, first_fail_idx=0, first_fail_valid=1.
- All fail: expected=16'h9669.
  - Required: fail_count=16 (5'b10000, checks the width), first_fail_idx=0, pass=0.
- Start ignored: pulse start again at cycle 10 of a run and toggle expected mid-run.
  - Required: done still at cycle 33 and results unchanged from the clean run.
- Reset mid-run: assert rst at cycle 12 for 1 cycle.
  - Required: next cycle shows busy=0, dut_in=0, fail_count=0, and no done pulse.
  - A following start completes a normal clean run.
- Timing with SETTLE_CYC=3, N=2: AND DUT model, expected=4'b1000.
  - Required: each vector held 4 cycles, done 17 cycles after start, pass=1.
